board_gen_param: RTL

- Parametrised pseudo-random game-board generator for the Memory-Matrix game.
- A start pulse makes it search a free-running Galois LFSR for a candidate board whose lit-cell count lies in a programmable [min_lit, max_lit] window. It then registers that board and holds it valid until the next start.
- If no candidate is found within a bounded number of tries, it falls back to a deterministic pattern.
- Sits between the game controller and the board-display/compare logic; replaces the fixed 8-cell generator for larger grids and difficulty levels.

---
 rtl/board_pkg.sv | 29 ++
 rtl/board_lfsr.sv | 36 +++
 rtl/board_gen_param.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the Memory-Matrix board generator.
// Provides the FSM state encoding, a constant clog2 helper and default
// maximal-length Galois feedback masks for common LFSR widths.
package board_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [7:0]  TAP_MASK_8  = 8'hB8;
    localparam logic [15:0] TAP_MASK_16 = 16'hB400;
    localparam logic [23:0] TAP_MASK_24 = 24'hE10000;
    localparam logic [31:0] TAP_MASK_32 = 32'hA3000000;

    // ceil(log2(value)); the bit count needed to hold value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/board_lfsr.sv
// Free-running Galois LFSR used as the entropy source for board candidates.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset, loads SEED
//   seed_load  replace this cycle's step with seed_in (ignored if seed_in == 0)
//   seed_in    new seed value
//   lfsr       current register value
module board_lfsr
    import board_pkg::*;
#(
    parameter int                 LFSR_W   = 16,
    parameter logic [LFSR_W-1:0]  TAP_MASK = TAP_MASK_16,
    parameter logic [LFSR_W-1:0]  SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [LFSR_W-1:0] lfsr
);

    // A zero seed would lock the LFSR at zero forever, so it is dropped
    // and the normal step is taken instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (seed_load && (seed_in != '0)) begin
            lfsr <= seed_in;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ TAP_MASK;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

endmodule

// File: rtl/board_gen_param.sv
// Pseudo-random game-board generator for the Memory-Matrix game.
// On start it evaluates one LFSR candidate per cycle until one has a lit-cell
// count inside the clamped [min_lit, max_lit] window, or falls back to a
// pattern with the low eff_min cells lit after MAX_TRIES candidates.
// Ports:
//   clk, reset          clock / asynchronous active-high reset
//   start               request a new board (sampled in IDLE and READY)
//   seed_load, seed_in  reseed the LFSR (zero seed ignored)
//   min_lit, max_lit    requested lit-cell window, sampled every GEN cycle
//   board               registered board, bit i = cell i lit
//   board_valid         board holds a completed result
//   busy                search in progress
//   fallback            board is the fallback pattern
//   tries               candidates examined for the current board
module board_gen_param
    import board_pkg::*;
#(
    parameter int                 N_CELLS   = 16,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  TAP_MASK  = TAP_MASK_16,
    parameter logic [LFSR_W-1:0]  SEED      = 16'hACE1,
    parameter int                 MAX_TRIES = 64,
    localparam int                CNT_W     = clog2(N_CELLS + 1),
    localparam int                TRY_W     = clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_in,
    input  logic [CNT_W-1:0]   min_lit,
    input  logic [CNT_W-1:0]   max_lit,
    output logic [N_CELLS-1:0] board,
    output logic               board_valid,
    output logic               busy,
    output logic               fallback,
    output logic [TRY_W-1:0]   tries
);

    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_CELLS);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    logic [LFSR_W-1:0]  lfsr;
    logic [N_CELLS-1:0] cand;
    logic [N_CELLS-1:0] fb_pattern;
    logic [CNT_W-1:0]   pop;
    logic [CNT_W-1:0]   eff_min;
    logic [CNT_W-1:0]   eff_max;
    logic               in_window;
    state_t             state;

    // Clamp the lower bound to the board size.
    function automatic logic [CNT_W-1:0] clamp_min(input logic [CNT_W-1:0] lo);
        return (lo > N_CNT) ? N_CNT : lo;
    endfunction

    // An inverted window collapses onto eff_min; an oversized one onto
    // N_CELLS, so the window is never empty.
    function automatic logic [CNT_W-1:0] clamp_max(input logic [CNT_W-1:0] hi,
                                                   input logic [CNT_W-1:0] lo_eff);
        logic [CNT_W-1:0] m;
        m = (hi < lo_eff) ? lo_eff : hi;
        return (m > N_CNT) ? N_CNT : m;
    endfunction

    board_lfsr #(
        .LFSR_W   (LFSR_W),
        .TAP_MASK (TAP_MASK),
        .SEED     (SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .lfsr      (lfsr)
    );

    assign cand = lfsr[N_CELLS-1:0];

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            pop = pop + CNT_W'(cand[i]);
        end
    end

    assign eff_min   = clamp_min(min_lit);
    assign eff_max   = clamp_max(max_lit, eff_min);
    assign in_window = (pop >= eff_min) && (pop <= eff_max);

    always_comb begin
        fb_pattern = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            fb_pattern[i] = (CNT_W'(i) < eff_min);
        end
    end

    // board is only ever written on the GEN -> READY transition (or reset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            board       <= '0;
            board_valid <= 1'b0;
            busy        <= 1'b0;
            fallback    <= 1'b0;
            tries       <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (start) begin
                        state       <= GEN;
                        busy        <= 1'b1;
                        board_valid <= 1'b0;
                        fallback    <= 1'b0;
                        tries       <= '0;
                    end
                end
                GEN: begin
                    tries <= tries + TRY_W'(1);
                    if (in_window) begin
                        board       <= cand;
                        board_valid <= 1'b1;
                        busy        <= 1'b0;
                        state       <= READY;
                    end else if (tries == LAST_TRY) begin
                        board       <= fb_pattern;
                        fallback    <= 1'b1;
                        board_valid <= 1'b1;
                        busy        <= 1'b0;
                        state       <= READY;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
